// File: rtl/decimator_pkg.sv
// Shared defaults and limits for the decimator block.
package decimator_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DECIM_LOG2_DEF = 2;
  localparam int DECIM_LOG2_MAX = 8;

  // Decimation factor for a given log2 setting.
  function automatic int decim_factor(input int log2_n);
    return 32'sd1 << log2_n;
  endfunction

endpackage

// File: rtl/decimator_counter.sv
// Frame counter for the decimator: tracks the sample index within each
// N-sample frame and flags the sample that matches the requested phase.
module decim_counter
  import decimator_pkg::*;
#(
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ce,
  input  logic                  i_resync,
  input  logic [DECIM_LOG2-1:0] i_phase,
  output logic [DECIM_LOG2-1:0] cnt,
  output logic                  sel
);

  logic [DECIM_LOG2-1:0] cnt_r;
  logic [DECIM_LOG2-1:0] idx_s;
  logic [DECIM_LOG2-1:0] cnt_next_s;
  logic                  sel_s;

  // Index of the current sample and next counter value; resync forces index 0.
  always_comb begin
    idx_s      = cnt_r;
    cnt_next_s = cnt_r;
    sel_s      = 1'b0;
    if (i_resync) begin
      idx_s = '0;
    end else begin
      idx_s = cnt_r;
    end
    if (i_ce) begin
      // Power-of-two frame length, so the natural wrap gives N-1 -> 0.
      cnt_next_s = idx_s + DECIM_LOG2'(1);
      sel_s      = (idx_s == i_phase);
    end else if (i_resync) begin
      cnt_next_s = '0;
      sel_s      = 1'b0;
    end else begin
      cnt_next_s = cnt_r;
      sel_s      = 1'b0;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;
  assign sel = sel_s;

endmodule

// File: rtl/decimator.sv
// Keeps one sample out of every 2^DECIM_LOG2 input strobes.
// Optional macro DECIMATOR_DEBUG_EN exposes o_cnt and o_sel for observation.
module decimator
  import decimator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic        [DECIM_LOG2-1:0] i_phase,
  input  logic                         i_resync,
  output logic signed [DATA_WIDTH-1:0] data_out,
`ifdef DECIMATOR_DEBUG_EN
  output logic        [DECIM_LOG2-1:0] o_cnt,
  output logic                         o_sel,
`endif
  output logic                         o_ce,
  output logic                         o_overrun
);

  logic        [DECIM_LOG2-1:0] cnt_s;
  logic                         sel_s;
  logic signed [DATA_WIDTH-1:0] data_out_r;
  logic                         o_ce_r;
  logic                         overrun_r;
  logic                         prev_ce_r;

  decim_counter #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .i_ce     (i_ce),
    .i_resync (i_resync),
    .i_phase  (i_phase),
    .cnt      (cnt_s),
    .sel      (sel_s)
  );

  // Output sample register and its one-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= '0;
      o_ce_r     <= 1'b0;
    end else begin
      o_ce_r <= sel_s;
      if (sel_s) begin
        data_out_r <= data_in;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  // Sticky overrun: strobes on back-to-back cycles break the upstream contract.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ce_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      prev_ce_r <= i_ce;
      if (i_ce && prev_ce_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign data_out  = data_out_r;
  assign o_ce      = o_ce_r;
  assign o_overrun = overrun_r;

`ifdef DECIMATOR_DEBUG_EN
  logic sel_r;

  // Registered copy of the select decision for external observation.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r <= 1'b0;
    end else begin
      sel_r <= sel_s;
    end
  end

  assign o_cnt = cnt_s;
  assign o_sel = sel_r;
`endif

endmodule

// File: tb/tb_decimator.sv
// Scoreboard bench for decimator: stimulus pushes expected outputs, a monitor checks them.
module tb_decimator;

  localparam int DW = 8;
  localparam int DL = 2;
  localparam int N  = 1 << DL;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_ce;
  logic signed [DW-1:0] data_in;
  logic        [DL-1:0] i_phase;
  logic                 i_resync;
  logic signed [DW-1:0] data_out;
  logic                 o_ce;
  logic                 o_overrun;
`ifdef DECIMATOR_DEBUG_EN
  logic        [DL-1:0] o_cnt;
  logic                 o_sel;
`endif

  decimator #(.DATA_WIDTH(DW), .DECIM_LOG2(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_ce      (i_ce),
    .data_in   (data_in),
    .i_phase   (i_phase),
    .i_resync  (i_resync),
    .data_out  (data_out),
`ifdef DECIMATOR_DEBUG_EN
    .o_cnt     (o_cnt),
    .o_sel     (o_sel),
`endif
    .o_ce      (o_ce),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   running = 1'b0;

  // Reference model state: frame position, last kept sample, overrun flag.
  int   m_idx  = 0;
  int   m_dout = 0;
  bit   m_ovr  = 1'b0;
  bit   m_prev = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after this edge.
  task automatic apply(input bit rst, input bit ce, input int d, input bit rs);
    int  idx;
    bit  keep;
    reset    = rst;
    i_ce     = ce;
    data_in  = DW'(d);
    i_resync = rs;
    keep     = 1'b0;
    if (!rst && ce) begin
      idx  = rs ? 0 : m_idx;
      keep = (idx == int'(i_phase));
      if (keep) q.push_back('{data: d, cyc: cyc + 1});
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_idx = 0; m_dout = 0; m_ovr = 1'b0; m_prev = 1'b0;
      q.delete();
    end else begin
      if (ce) m_idx = ((rs ? 0 : m_idx) + 1) % N;
      else if (rs) m_idx = 0;
      if (keep) m_dout = d;
      if (ce && m_prev) m_ovr = 1'b1;
      m_prev = ce;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic stream(input int v[8]);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, v[i], 1'b0);
      apply(1'b0, 1'b0, 0, 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a strobe is due or seen.
  always @(negedge clk) begin
    if (running) begin
      bit exp_ce;
      exp_ce = (q.size() > 0) && (q[0].cyc == cyc);
      if (o_ce || exp_ce) begin
        check("o_ce", int'(o_ce), int'(exp_ce));
        if (exp_ce) begin
          check("data_out_strobe", int'(data_out), q[0].data);
          void'(q.pop_front());
        end
      end
      check("data_out_hold", int'(data_out), m_dout);
      check("o_overrun", int'(o_overrun), int'(m_ovr));
    end
  end

  initial begin
    int s1[8] = '{10, -20, 30, -40, 50, 0, 100, -127};
    reset = 1'b1; i_ce = 1'b0; data_in = '0; i_phase = '0; i_resync = 1'b0;
    apply(1'b1, 1'b0, 0, 1'b0);
    apply(1'b1, 1'b0, 0, 1'b0);
    running = 1'b1;

    // Phase 0 then phase 3 on the same stream.
    i_phase = 2'd0;
    stream(s1);
    idle(3);
    apply(1'b1, 1'b0, 0, 1'b0);
    i_phase = 2'd3;
    stream(s1);
    idle(3);

    // Resync with a strobe after two samples.
    apply(1'b1, 1'b0, 0, 1'b0);
    i_phase = 2'd0;
    apply(1'b0, 1'b1, 1, 1'b0); idle(1);
    apply(1'b0, 1'b1, 2, 1'b0); idle(1);
    apply(1'b0, 1'b1, 77, 1'b1); idle(1);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 80 + i, 1'b0); idle(1);
    end
    // Resync without a strobe.
    apply(1'b0, 1'b1, 5, 1'b0); idle(1);
    apply(1'b0, 1'b0, 0, 1'b1);
    apply(1'b0, 1'b1, 66, 1'b0); idle(2);

    // Back-to-back strobes set overrun; reset clears it.
    apply(1'b0, 1'b1, 11, 1'b0);
    apply(1'b0, 1'b1, 12, 1'b0);
    idle(4);
    apply(1'b1, 1'b0, 0, 1'b0);
    idle(2);

    // Reset mid-frame with a strobe present.
    apply(1'b0, 1'b1, 21, 1'b0); idle(1);
    apply(1'b0, 1'b1, 22, 1'b0); idle(1);
    apply(1'b1, 1'b1, 55, 1'b0); idle(2);
    apply(1'b0, 1'b1, 33, 1'b0); idle(2);

    // Extreme values at the selected index.
    i_phase = 2'd1;
    apply(1'b0, 1'b0, 0, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b0); idle(1);
    apply(1'b0, 1'b1, 127, 1'b0); idle(1);
    apply(1'b0, 1'b1, 3, 1'b0); idle(1);
    apply(1'b0, 1'b1, 4, 1'b0); idle(1);
    apply(1'b0, 1'b1, 5, 1'b0); idle(1);
    apply(1'b0, 1'b1, -128, 1'b0); idle(3);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      bit rst, ce, rs;
      if ($urandom_range(0, 9) == 0) i_phase = DL'($urandom_range(0, N - 1));
      rst = ($urandom_range(0, 49) == 0);
      ce  = ($urandom_range(0, 9) < 4);
      rs  = ($urandom_range(0, 19) == 0);
      apply(rst, ce, int'($signed(DW'($urandom))), rs);
    end
    idle(3);

    check("scoreboard_drained", q.size(), 0);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
